// File: rtl/ffi_pkg.sv
// Shared types and width helpers for the feed-forward-inhibition window controller.
package ffi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        INHIBIT = 2'd2
    } ffi_state_t;

    // Width helpers: spike counter holds 0..n, window counter holds 0..len-1
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int win_w(input int len);
        return $clog2(len);
    endfunction

    localparam int DEF_NUM_SPIKES = 8;
    localparam int DEF_GAMMA_LEN  = 16;
    localparam int CNT_W          = $clog2(DEF_NUM_SPIKES + 1);
    localparam int WIN_W          = $clog2(DEF_GAMMA_LEN);

endpackage

// File: rtl/ffi_budget_grant.sv
// Lowest-index-first grant of up to 'budget' eligible lanes; purely combinational.
module ffi_budget_grant
    import ffi_pkg::*;
#(
    parameter int N  = DEF_NUM_SPIKES,
    parameter int CW = CNT_W
) (
    input  logic [N-1:0]  eligible,
    input  logic [CW-1:0] budget,
    output logic [N-1:0]  grant
);

    logic [CW-1:0] left;

    // Walk lanes from index 0 and hand out grants until the budget is spent
    always_comb begin
        grant = '0;
        left  = budget;
        for (int i = 0; i < N; i++) begin
            if (eligible[i] && (left != '0)) begin
                grant[i] = 1'b1;
                left     = left - CW'(1);
            end
        end
    end

endmodule

// File: rtl/ffi_window_ctrl.sv
// Gamma-window spike controller: grants at most FFI_MAX lanes per window,
// each lane once, then inhibits until the window closes or restarts.
// Optional macro FFI_STATS_EN adds a saturating drop_count output.
module ffi_window_ctrl
    import ffi_pkg::*;
#(
    parameter int NUM_SPIKES = 8,
    parameter int FFI_MAX    = 3,
    parameter int GAMMA_LEN  = 16
) (
    input  logic                             clk,
    input  logic                             rst_l,
    input  logic                             gamma_start,
    input  logic [NUM_SPIKES-1:0]            spike_in_l,
    output logic [NUM_SPIKES-1:0]            spike_out_l,
    output logic                             inhibit,
    output logic                             window_active,
    output logic [cnt_w(NUM_SPIKES)-1:0]     spike_count
`ifdef FFI_STATS_EN
    ,
    output logic [15:0]                      drop_count
`endif
);

    localparam int CW = cnt_w(NUM_SPIKES);
    localparam int WW = win_w(GAMMA_LEN);

    ffi_state_t            state, state_nx;
    logic [WW-1:0]         cnt, cnt_nx;
    logic [CW-1:0]         count_nx, n_grant, budget;
    logic [NUM_SPIKES-1:0] fired, fired_nx, out_nx, eligible, grant;
    logic                  last_cyc;

    // Requests in a gamma_start cycle are discarded: the window (re)opens next cycle
    assign eligible = (state == ACTIVE && !gamma_start) ? (~spike_in_l & ~fired) : '0;
    assign budget   = CW'(FFI_MAX) - spike_count;
    assign last_cyc = (cnt == WW'(GAMMA_LEN - 1));

    ffi_budget_grant #(.N(NUM_SPIKES), .CW(CW)) u_grant (
        .eligible (eligible),
        .budget   (budget),
        .grant    (grant)
    );

    // State register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and next datapath values; restart beats expiry
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        count_nx = spike_count;
        fired_nx = fired;
        out_nx   = '1;
        n_grant  = '0;
        for (int i = 0; i < NUM_SPIKES; i++) n_grant = n_grant + CW'(grant[i]);
        if (gamma_start) begin
            state_nx = ACTIVE;
            cnt_nx   = '0;
            count_nx = '0;
            fired_nx = '0;
        end else if (state != IDLE) begin
            out_nx   = ~grant;
            count_nx = spike_count + n_grant;
            fired_nx = fired | grant;
            if (last_cyc) begin
                state_nx = IDLE;
            end else begin
                cnt_nx = cnt + WW'(1);
                if (state == ACTIVE && count_nx == CW'(FFI_MAX)) state_nx = INHIBIT;
            end
        end
    end

    // Registered datapath and status outputs
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt           <= '0;
            spike_count   <= '0;
            fired         <= '0;
            spike_out_l   <= '1;
            inhibit       <= 1'b0;
            window_active <= 1'b0;
        end else begin
            cnt           <= cnt_nx;
            spike_count   <= count_nx;
            fired         <= fired_nx;
            spike_out_l   <= out_nx;
            inhibit       <= (state_nx == INHIBIT);
            window_active <= (state_nx != IDLE);
        end
    end

`ifdef FFI_STATS_EN
    logic [15:0] drop_inc;
    logic [16:0] drop_sum;

    // Lanes lost this cycle: eligible but over budget, or requesting while inhibited
    always_comb begin
        drop_inc = '0;
        for (int i = 0; i < NUM_SPIKES; i++) begin
            drop_inc = drop_inc + 16'(eligible[i] & ~grant[i]);
            if (state == INHIBIT && !gamma_start) drop_inc = drop_inc + 16'(~spike_in_l[i]);
        end
        drop_sum = {1'b0, drop_count} + {1'b0, drop_inc};
    end

    // Saturating drop counter, cleared only by reset
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) drop_count <= '0;
        else        drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
`endif

endmodule

// File: doc/ffi_window_ctrl.md
FFI_WINDOW_CTRL -- requirements
Module: ffi_window_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_SPIKES, default 8: number of neuron spike lanes.
REQ-002 The block SHALL have parameter FFI_MAX, default 3: maximum spikes granted per gamma window (1..NUM_SPIKES).
REQ-003 The block SHALL have parameter GAMMA_LEN, default 16: window length in cycles (>=2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst_l, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port gamma_start, input, 1 bit: pulse that opens a new window.
REQ-007 The block SHALL have port spike_in_l, input, NUM_SPIKES bits: active-low spike requests, one bit per lane.
REQ-008 The block SHALL have port spike_out_l, output, NUM_SPIKES bits: registered, active-low granted spikes.
REQ-009 The block SHALL have port inhibit, output, 1 bit: high while the window budget is exhausted.
REQ-010 The block SHALL have port window_active, output, 1 bit: high in ACTIVE or INHIBIT.
REQ-011 The block SHALL have port spike_count, output, $clog2(NUM_SPIKES+1) bits: spikes granted so far in the current window.

Function
REQ-012 The FSM SHALL have states IDLE, ACTIVE and INHIBIT.
REQ-013 The transitions SHALL be:
- IDLE->ACTIVE on gamma_start.
- ACTIVE->INHIBIT when spike_count reaches FFI_MAX.
- ACTIVE or INHIBIT->IDLE when the window counter equals GAMMA_LEN-1.
REQ-014 When gamma_start arrives in ACTIVE or INHIBIT, the block SHALL restart the window: counter=0, spike_count=0, fired mask cleared, state ACTIVE; this takes priority over window expiry in the same cycle.
REQ-015 The window counter SHALL be 0 in the first ACTIVE cycle and SHALL increment every cycle while window_active; it SHALL NOT wrap, and exit occurs at GAMMA_LEN-1.
REQ-016 A lane SHALL be eligible when spike_in_l[i]==0, state is ACTIVE, and the lane's fired-mask bit is clear; each lane is granted at most once per window.
REQ-017 Eligible lanes SHALL be granted in lowest-index-first order, up to budget = FFI_MAX - spike_count; excess eligible lanes SHALL be dropped and SHALL NOT be retried.
REQ-018 Grants SHALL appear on spike_out_l (granted bit 0, all others 1) exactly one cycle after the requesting cycle, and SHALL be held for one cycle only.
REQ-019 spike_count and the fired mask SHALL update in the same edge as spike_out_l; spike_count SHALL never exceed FFI_MAX.
REQ-020 In IDLE and INHIBIT, spike_out_l SHALL be all ones regardless of spike_in_l.
REQ-021 Requests present in the cycle gamma_start is sampled from IDLE SHALL be ignored; the first grantable cycle is the next one.
REQ-022 inhibit SHALL equal (state==INHIBIT) and SHALL be registered.

Reset
REQ-023 While rst_l==0 the block SHALL hold: state IDLE, spike_out_l all ones, inhibit 0, window_active 0, spike_count 0, counter 0, fired mask 0.
REQ-024 Reset asserted mid-window SHALL abort the window immediately; the first window after release requires a new gamma_start.

Configuration
REQ-025 With FFI_STATS_EN defined, the block SHALL add output drop_count (16 bits, saturating at 16'hFFFF, reset 0): it counts eligible-but-dropped lanes plus lanes requesting during INHIBIT, and is cleared only by reset.
REQ-026 Without FFI_STATS_EN, the block SHALL have neither the drop_count port nor its logic.

Structure
REQ-027 Package ffi_pkg SHALL hold the state enum ffi_state_t and width localparams (CNT_W, WIN_W).
REQ-028 Sub-module ffi_budget_grant SHALL implement REQ-017 as purely combinational logic: inputs eligible mask and budget; output grant mask. It is instantiated once.

Verification
REQ-029 Default parameters, gamma_start, then spike_in_l=8'b1111_0000 in cycle 1 -> cycle 2 spike_out_l=8'b1111_1000, spike_count=3, inhibit=1.
REQ-030 Lane 2 requests every cycle of a window -> exactly one low pulse on lane 2, spike_count=1, no inhibit.
REQ-031 No requests -> window_active high for exactly 16 cycles, then IDLE with spike_count reset only at the next gamma_start.
REQ-032 gamma_start re-asserted at counter=10 in INHIBIT -> next cycle ACTIVE, spike_count=0, and lane 0 is grantable again.
REQ-033 rst_l pulsed low at counter=5 with grants pending -> spike_out_l=8'hFF immediately (asynchronous), state IDLE.
REQ-034 FFI_STATS_EN defined, 8'h00 requested for 2 cycles in one window -> drop_count=13 (5 dropped in the first cycle, 8 during INHIBIT).
